mult_red_448_digit_serial: RTL and testbench

//  Parametrised digit-serial GF(p) multiplier, p = 2^448 - 2^224 - 1 (Curve448 field).

---
 rtl/mult_red_448_digit_serial.sv | 180 ++++++++++++++++++
 tb/tb_mult_red_448_digit_serial.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_red_448_digit_serial.sv
// Digit-serial multiplier over GF(2^448 - 2^224 - 1) with canonical output and an
// optional mod-(2^CHK_W - 1) residue check on the raw 896-bit product.
module mult_red_448_digit_serial #(
    parameter int DIGIT_W  = 56,
    parameter int CHECK_EN = 1,
    parameter int CHK_W    = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [447:0] iX,
    input  logic [447:0] iY,
    output logic         busy,
    output logic         done,
    output logic [447:0] oO,
    output logic         err
);
    // state | meaning
    // IDLE  | waiting for start
    // MUL   | one iY digit per cycle accumulated into acc
    // RED1  | fold acc (896b) to T1 (673b)
    // RED2  | fold T1 to T2 (451b)
    // RED3  | final fold, conditional subtract of p, load oO
    // DONE  | one-cycle done pulse; a new start is accepted here too

    localparam int NUM_DIGITS = 448 / DIGIT_W;
    localparam int CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_DIGITS - 1);
    localparam logic [448:0] P = {1'b0, {223{1'b1}}, 1'b0, {224{1'b1}}};

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_RED1, S_RED2, S_RED3, S_DONE} state_t;

    state_t             state, state_nxt;
    logic               accept;
    logic [CNT_W-1:0]   cnt;
    logic [447:0]       x_r, y_r;
    logic [895:0]       acc;
    logic [672:0]       t1;
    logic [450:0]       t2;
    logic [DIGIT_W-1:0] digit;
    logic [895:0]       partial;
    logic [448:0]       t3, t3_sub;
    logic [447:0]       red_out;

    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: if (start) state_nxt = S_MUL;
            S_MUL: begin
                busy = 1'b1;
                if (cnt == CNT_LAST) state_nxt = S_RED1;
            end
            S_RED1: begin
                busy      = 1'b1;
                state_nxt = S_RED2;
            end
            S_RED2: begin
                busy      = 1'b1;
                state_nxt = S_RED3;
            end
            S_RED3: begin
                busy      = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = start ? S_MUL : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign accept  = start && !busy;
    assign digit   = y_r[int'(cnt)*DIGIT_W +: DIGIT_W];
    assign partial = ({448'd0, x_r} * {{(896-DIGIT_W){1'b0}}, digit}) << (int'(cnt)*DIGIT_W);

    // 2^448 == 2^224 + 1 (mod p): every fold adds the high part at bit 0 and bit 224
    assign t3      = {1'b0, t2[447:0]} + {446'd0, t2[450:448]} + ({446'd0, t2[450:448]} << 224);
    assign t3_sub  = t3 - P;
    assign red_out = (t3 >= P) ? t3_sub[447:0] : t3[447:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
            x_r <= '0;
            y_r <= '0;
            acc <= '0;
            t1  <= '0;
            t2  <= '0;
            oO  <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        x_r <= iX;
                        y_r <= iY;
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                S_MUL: begin
                    acc <= acc + partial;
                    cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
                end
                S_RED1: t1 <= {225'd0, acc[447:0]} + {225'd0, acc[895:448]}
                              + {1'b0, acc[895:448], 224'd0};
                S_RED2: t2 <= {3'd0, t1[447:0]} + {226'd0, t1[672:448]}
                              + {2'b0, t1[672:448], 224'd0};
                S_RED3: oO <= red_out;
                default: ;
            endcase
        end
    end

    generate
        if (CHECK_EN != 0) begin : g_chk
            localparam int NCH = (896 + CHK_W - 1) / CHK_W;

            logic [CHK_W-1:0] rx, ry, rp;
            logic             err_r;

            // Sum of CHK_W-bit chunks with end-around carry, i.e. value mod 2^CHK_W - 1
            function automatic logic [CHK_W-1:0] res_of(input logic [895:0] v);
                logic [NCH*CHK_W-1:0] pad;
                logic [CHK_W:0]       s;
                pad        = '0;
                pad[895:0] = v;
                s          = '0;
                for (int i = 0; i < NCH; i++) begin
                    s = {1'b0, s[CHK_W-1:0]} + {1'b0, pad[i*CHK_W +: CHK_W]};
                    s = {1'b0, s[CHK_W-1:0]} + {{CHK_W{1'b0}}, s[CHK_W]};
                end
                return s[CHK_W-1:0];
            endfunction

            function automatic logic [CHK_W-1:0] mul_mod(input logic [CHK_W-1:0] a,
                                                         input logic [CHK_W-1:0] b);
                logic [2*CHK_W-1:0] prod;
                logic [CHK_W:0]     s;
                prod = {{CHK_W{1'b0}}, a} * {{CHK_W{1'b0}}, b};
                s    = {1'b0, prod[CHK_W-1:0]} + {1'b0, prod[2*CHK_W-1:CHK_W]};
                s    = {1'b0, s[CHK_W-1:0]} + {{CHK_W{1'b0}}, s[CHK_W]};
                return s[CHK_W-1:0];
            endfunction

            // All-ones and zero are the same residue
            function automatic logic [CHK_W-1:0] canon(input logic [CHK_W-1:0] v);
                return (v == '1) ? '0 : v;
            endfunction

            always_ff @(posedge clk) begin
                if (!reset) begin
                    rx    <= '0;
                    ry    <= '0;
                    rp    <= '0;
                    err_r <= 1'b0;
                end else begin
                    if (accept) begin
                        rx <= res_of({448'd0, iX});
                        ry <= res_of({448'd0, iY});
                    end
                    if (state == S_RED1) rp <= res_of(acc);
                    if (state == S_RED3) err_r <= (canon(mul_mod(rx, ry)) != canon(rp));
                end
            end

            assign err = err_r;
        end else begin : g_nochk
            assign err = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_mult_red_448_digit_serial.sv
// Self-checking bench for mult_red_448_digit_serial: fixed vectors, handshake corner
// cases, injected accumulator fault, mid-op reset and random operands vs (x*y) % p.
module tb_mult_red_448_digit_serial;
    localparam logic [447:0] P    = {{223{1'b1}}, 1'b0, {224{1'b1}}};
    localparam logic [447:0] ALL1 = '1;
    localparam logic [447:0] TWO224 = 448'd1 << 224;
    localparam int LAT  = 12;
    localparam int BUSY = 11;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [447:0] iX, iY;
    logic         busy, done, err;
    logic [447:0] oO;

    int checks = 0;
    int errors = 0;

    logic [895:0] fault_val;

    typedef struct packed {
        logic [447:0] x;
        logic [447:0] y;
        logic [447:0] exp;
    } vec_t;

    vec_t vecs[8];

    mult_red_448_digit_serial #(.DIGIT_W(56), .CHECK_EN(1), .CHK_W(32)) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .iX   (iX),
        .iY   (iY),
        .busy (busy),
        .done (done),
        .oO   (oO),
        .err  (err)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1, "watchdog");
    end

    function automatic logic [447:0] ref_mul(input logic [447:0] a, input logic [447:0] b);
        logic [895:0] prod;
        prod = {448'd0, a} * {448'd0, b};
        prod = prod % {448'd0, P};
        return prod[447:0];
    endfunction

    function automatic logic [447:0] rand_op();
        logic [447:0] v;
        v = '0;
        case ($urandom_range(0, 9))
            0: v = '0;
            1: v = 448'd1;
            2: v = P - 448'd1;
            3: v = ALL1;
            4: v = P;
            default: for (int i = 0; i < 14; i++) v[i*32 +: 32] = $urandom();
        endcase
        return v;
    endfunction

    task automatic check_val(input string name, input logic [447:0] act, input logic [447:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Drives one op and waits (bounded) for done; lat counts negedges after the start cycle
    task automatic run_op(input logic [447:0] x, input logic [447:0] y,
                          output logic [447:0] res, output logic e,
                          output int lat, output int busy_cnt);
        @(negedge clk);
        iX    = x;
        iY    = y;
        start = 1'b1;
        lat      = 0;
        busy_cnt = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (busy) busy_cnt++;
        end while (!done && lat < 40);
        res = oO;
        e   = err;
    endtask

    initial begin
        logic [447:0] res, x1, y1, x2, y2;
        logic         e;
        int           lat, bc, n, seen;

        reset = 1'b0;
        start = 1'b0;
        iX    = '0;
        iY    = '0;

        vecs[0] = '{x: 448'd2,        y: 448'd3,        exp: 448'd6};
        vecs[1] = '{x: P - 448'd1,    y: P - 448'd1,    exp: 448'd1};
        vecs[2] = '{x: P,             y: 448'd5,        exp: 448'd0};
        vecs[3] = '{x: ALL1,          y: ALL1,          exp: TWO224 + 448'd1};
        vecs[4] = '{x: 448'd0,        y: P - 448'd1,    exp: 448'd0};
        vecs[5] = '{x: 448'd1,        y: P - 448'd1,    exp: P - 448'd1};
        vecs[6] = '{x: TWO224,        y: TWO224,        exp: TWO224 + 448'd1};
        vecs[7] = '{x: P - 448'd1,    y: 448'd2,        exp: P - 448'd2};

        repeat (3) @(negedge clk);
        check_int("reset_busy", int'(busy), 0);
        check_int("reset_done", int'(done), 0);
        check_int("reset_err", int'(err), 0);
        check_val("reset_oO", oO, '0);
        reset = 1'b1;

        // Fixed vectors, including done pulse width and result hold
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].x, vecs[i].y, res, e, lat, bc);
            check_val($sformatf("vec%0d_oO", i), res, vecs[i].exp);
            check_int($sformatf("vec%0d_err", i), int'(e), 0);
            check_int($sformatf("vec%0d_latency", i), lat, LAT);
            check_int($sformatf("vec%0d_busy_cycles", i), bc, BUSY);
            @(negedge clk);
            check_int($sformatf("vec%0d_done_one_cycle", i), int'(done), 0);
            check_val($sformatf("vec%0d_oO_held", i), oO, vecs[i].exp);
        end

        // Start held through busy with changing operands; re-accept in DONE
        x1 = {$urandom(), $urandom(), $urandom(), $urandom(), 320'd12345};
        y1 = P - 448'd7;
        x2 = ALL1 - 448'd99;
        y2 = {$urandom(), $urandom(), 384'd77};
        @(negedge clk);
        iX = x1; iY = y1; start = 1'b1;
        @(negedge clk);
        iX = x2; iY = y2;
        n = 1;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_int("b2b_first_latency", n, LAT);
        check_val("b2b_first_oO", oO, ref_mul(x1, y1));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 40);
        start = 1'b0;
        check_int("b2b_second_latency", n, LAT);
        check_val("b2b_second_oO", oO, ref_mul(x2, y2));
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        check_int("b2b_no_third_op", seen, 0);

        // Accumulator bit flipped mid-MUL must raise err
        x1 = {$urandom(), $urandom(), $urandom(), 352'h1234_5678_9abc};
        y1 = {$urandom(), $urandom(), 384'hfeed_beef_0001};
        @(negedge clk);
        iX = x1; iY = y1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        fault_val = dut.acc ^ (896'd1 << 300);
        force dut.acc = fault_val;
        n = 3;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        release dut.acc;
        check_int("fault_latency", n, LAT);
        check_int("fault_err", int'(err), 1);

        // Reset in the middle of MUL discards the op
        @(negedge clk);
        iX = x1; iY = y1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check_int("midreset_busy", int'(busy), 0);
        check_int("midreset_done", int'(done), 0);
        check_int("midreset_err", int'(err), 0);
        check_val("midreset_oO", oO, '0);
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) seen++;
        end
        check_int("midreset_no_done", seen, 0);

        run_op(x1, y1, res, e, lat, bc);
        check_val("rerun_oO", res, ref_mul(x1, y1));
        check_int("rerun_err", int'(e), 0);
        check_int("rerun_latency", lat, LAT);

        // Random operands against the arithmetic reference
        for (int i = 0; i < 2000; i++) begin
            x1 = rand_op();
            y1 = rand_op();
            run_op(x1, y1, res, e, lat, bc);
            check_val($sformatf("rand%0d_oO", i), res, ref_mul(x1, y1));
            check_int($sformatf("rand%0d_err", i), int'(e), 0);
            check_int($sformatf("rand%0d_latency", i), lat, LAT);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
